// File: rtl/instruction_loader_pkg.sv
// Shared types for the instruction loader: FSM states, 32-bit bus word, defaults.
// Byte order on the link is big-endian: the first byte of a word is bits [31:24],
// matching the assembler tooling that serialises the program image.
package instruction_loader_pkg;

    localparam int unsigned WORD_COUNT_DEF = 1024;
    localparam int unsigned LEN_W_DEF      = 16;
    localparam int unsigned BYTE_W         = 8;

    typedef logic [31:0] vec32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // States in which the loader consumes bytes from the link
    function automatic logic state_takes_bytes(input loader_state_t s);
        return (s == ST_HEADER) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/instruction_loader_word_packer.sv
// Packs four accepted bytes MSB-first into a word; word_ready_c flags the 4th byte.
module instruction_loader_word_packer
    import instruction_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output vec32_t            word_c,
    output logic              word_ready_c
);

    logic [23:0] shift;
    logic [1:0]  count;

    // Current byte completes the word combinationally so the top can register it
    assign word_c       = {shift, byte_data};
    assign word_ready_c = byte_en && (count == 2'd3);

    // Byte shift register and position counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift <= '0;
            count <= '0;
        end else if (clear) begin
            shift <= '0;
            count <= '0;
        end else if (byte_en) begin
            shift <= {shift[15:0], byte_data};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Instruction memory writer: takes a length-prefixed byte stream and writes IM words.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned WORD_COUNT = WORD_COUNT_DEF,
    parameter int unsigned LEN_W      = LEN_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byteValid,
    input  logic [BYTE_W-1:0] byteData,
    output logic              byteReady,
    output logic              imWriteEnable,
    output vec32_t            imWriteAddress,
    output vec32_t            imWriteData,
    output logic              cpuHold,
    output logic              loadDone,
    output logic              loadError
);

    localparam int unsigned AW = $clog2(WORD_COUNT);

    loader_state_t     state, state_next;
    logic              hdr_second;
    logic [BYTE_W-1:0] len_hi;
    logic [LEN_W-1:0]  length;
    logic [LEN_W-1:0]  hdr_len_c;
    logic [AW-1:0]     word_index;
    logic              accept_c;
    logic              clear_c;
    logic              data_en_c;
    logic              hdr_lo_c;
    logic              write_c;
    logic              done_next_c;
    vec32_t            word_c;
    logic              word_ready_c;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    assign accept_c  = byteValid && byteReady;
    assign hdr_len_c = LEN_W'({len_hi, byteData});

    instruction_loader_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear_c),
        .byte_en      (data_en_c),
        .byte_data    (byteData),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        clear_c    = 1'b0;
        data_en_c  = 1'b0;
        hdr_lo_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_HEADER;
                    clear_c    = 1'b1;
                end
            end
            ST_HEADER: begin
                if (accept_c && hdr_second) begin
                    hdr_lo_c = 1'b1;
                    if ((hdr_len_c == '0) || (32'(hdr_len_c) > WORD_COUNT)) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    data_en_c = 1'b1;
                    if (word_ready_c && ((32'(word_index) + 32'd1) == 32'(length))) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_DONE;
`endif
                    end
                end
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept_c) begin
                    state_next = (byteData == csum) ? ST_DONE : ST_ERROR;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_HEADER;
                    clear_c    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign write_c     = data_en_c && word_ready_c;
    // loadDone rises one cycle after entering DONE so it trails the final strobe
    assign done_next_c = (state == ST_DONE) && (state_next == ST_DONE);

    // Header capture, word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_second <= 1'b0;
            len_hi     <= '0;
            length     <= '0;
            word_index <= '0;
        end else if (clear_c) begin
            hdr_second <= 1'b0;
            len_hi     <= '0;
            length     <= '0;
            word_index <= '0;
        end else begin
            if ((state == ST_HEADER) && accept_c) begin
                hdr_second <= 1'b1;
                if (!hdr_second) begin
                    len_hi <= byteData;
                end
            end
            if (hdr_lo_c) begin
                length <= hdr_len_c;
            end
            if (write_c) begin
                word_index <= word_index + AW'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of data bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (clear_c) begin
            csum <= '0;
        end else if (data_en_c) begin
            csum <= csum ^ byteData;
        end
    end
`endif

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byteReady      <= 1'b0;
            imWriteEnable  <= 1'b0;
            imWriteAddress <= '0;
            imWriteData    <= '0;
            cpuHold        <= 1'b1;
            loadDone       <= 1'b0;
            loadError      <= 1'b0;
        end else begin
            byteReady     <= state_takes_bytes(state_next);
            imWriteEnable <= write_c;
            if (write_c) begin
                imWriteAddress <= 32'({word_index, 2'b00});
                imWriteData    <= word_c;
            end
            cpuHold   <= !done_next_c;
            loadDone  <= done_next_c;
            loadError <= (state_next == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader; honours LOADER_CHECKSUM_EN.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        byteReady;
    logic        imWriteEnable;
    logic [31:0] imWriteAddress;
    logic [31:0] imWriteData;
    logic        cpuHold;
    logic        loadDone;
    logic        loadError;

    int          total;
    int          bad;
    int          cyc;
    int          done_cyc;
    logic        prev_done;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [7:0]  stream[$];
    logic [31:0] exp_words[$];

    instruction_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .byteValid      (byteValid),
        .byteData       (byteData),
        .byteReady      (byteReady),
        .imWriteEnable  (imWriteEnable),
        .imWriteAddress (imWriteAddress),
        .imWriteData    (imWriteData),
        .cpuHold        (cpuHold),
        .loadDone       (loadDone),
        .loadError      (loadError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record IM writes and the cycle loadDone rises
    always @(negedge clk) begin
        if (imWriteEnable) begin
            wr_addr.push_back(imWriteAddress);
            wr_data.push_back(imWriteData);
            wr_cyc.push_back(cyc);
        end
        if (loadDone && !prev_done) done_cyc = cyc;
        prev_done = loadDone;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
    endtask

    // Serialise exp_words as length header + big-endian data (+ XOR checksum)
    task automatic build_stream();
        logic [7:0] x;
        int n;
        n = exp_words.size();
        x = 8'h00;
        stream.delete();
        stream.push_back(8'((n / 256) % 256));
        stream.push_back(8'(n % 256));
        foreach (exp_words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                stream.push_back(8'((exp_words[i] >> (8 * k)) & 32'hFF));
                x = x ^ 8'((exp_words[i] >> (8 * k)) & 32'hFF);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(x);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  budget;
        bit  sent;
        budget = 500;
        sent   = 1'b0;
        while (!sent && budget > 0) begin
            @(negedge clk);
            budget--;
            if (int'($urandom_range(99)) < gap) begin
                byteValid = 1'b0;
            end else begin
                byteValid = 1'b1;
                byteData  = b;
                if (byteReady) begin
                    @(posedge clk);
                    sent = 1'b1;
                end
            end
        end
        if (!sent) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_first(input int count, input int gap);
        for (int i = 0; i < count && i < stream.size(); i++) send_byte(stream[i], gap);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_flag();
        int n;
        n = 0;
        while (!(loadDone || loadError) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(loadDone || loadError)) chk("flag_timeout", 32'd0, 32'd1);
    endtask

    // Compare recorded writes and final flags against exp_words
    task automatic check_load(input string tag);
        wait_flag();
        @(negedge clk);
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < wr_addr.size(); i++) begin
            chk({tag, "_addr"}, wr_addr[i], 32'(i * 4));
            chk({tag, "_data"}, wr_data[i], exp_words[i]);
        end
        chk({tag, "_done"}, 32'(loadDone), 32'd1);
        chk({tag, "_err"}, 32'(loadError), 32'd0);
        chk({tag, "_hold"}, 32'(cpuHold), 32'd0);
        chk({tag, "_rdy"}, 32'(byteReady), 32'd0);
`ifndef LOADER_CHECKSUM_EN
        if (wr_cyc.size() > 0) chk({tag, "_done_lat"}, 32'(done_cyc), 32'(wr_cyc[$] + 1));
`endif
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; done_cyc = -1; prev_done = 1'b0;
        reset = 1'b1; start = 1'b0; byteValid = 1'b0; byteData = 8'h00;

        // 1: reset then idle with bytes offered but no start
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_log();
        byteValid = 1'b1;
        byteData  = 8'hA5;
        repeat (20) @(negedge clk);
        byteValid = 1'b0;
        chk("idle_rdy", 32'(byteReady), 32'd0);
        chk("idle_we", 32'(imWriteEnable), 32'd0);
        chk("idle_addr", imWriteAddress, 32'd0);
        chk("idle_data", imWriteData, 32'd0);
        chk("idle_hold", 32'(cpuHold), 32'd1);
        chk("idle_done", 32'(loadDone), 32'd0);
        chk("idle_err", 32'(loadError), 32'd0);
        chk("idle_nwr", 32'(wr_addr.size()), 32'd0);

        // 2: two-word directed image, valid held high
        clear_log();
        exp_words = '{32'h20080005, 32'h0000000C};
        build_stream();
        pulse_start();
        chk("start_rdy", 32'(byteReady), 32'd1);
        send_first(stream.size(), 0);
        check_load("two");
        for (int i = 1; i < wr_cyc.size(); i++) chk("two_bubble", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);

        // bytes offered in DONE are ignored
        byteValid = 1'b1;
        repeat (6) @(negedge clk);
        byteValid = 1'b0;
        chk("done_ign_nwr", 32'(wr_addr.size()), 32'd2);
        chk("done_stays", 32'(loadDone), 32'd1);

        // 3: bad lengths 0 and WORD_COUNT+1
        clear_log();
        pulse_start();
        chk("restart_done_clr", 32'(loadDone), 32'd0);
        chk("restart_hold", 32'(cpuHold), 32'd1);
        stream = '{8'h00, 8'h00};
        send_first(2, 0);
        chk("len0_err", 32'(loadError), 32'd1);
        chk("len0_hold", 32'(cpuHold), 32'd1);
        chk("len0_rdy", 32'(byteReady), 32'd0);
        pulse_start();
        chk("len0_clr", 32'(loadError), 32'd0);
        stream = '{8'h04, 8'h01};
        send_first(2, 0);
        chk("len1025_err", 32'(loadError), 32'd1);
        chk("len1025_done", 32'(loadDone), 32'd0);
        repeat (3) @(negedge clk);
        chk("badlen_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        chk("len1025_clr", 32'(loadError), 32'd0);

        // 4: full 1024-word random image with random valid gaps
        clear_log();
        exp_words.delete();
        for (int i = 0; i < 1024; i++) exp_words.push_back($urandom());
        build_stream();
        send_first(stream.size(), 30);
        check_load("full");
        if (wr_addr.size() > 0) chk("full_last_addr", wr_addr[$], 32'h00000FFC);

        // 5: reset after two of three words, then reload
        clear_log();
        exp_words = '{$urandom(), $urandom(), $urandom()};
        build_stream();
        pulse_start();
        send_first(10, 20);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_we", 32'(imWriteEnable), 32'd0);
        chk("rst_rdy", 32'(byteReady), 32'd0);
        chk("rst_addr", imWriteAddress, 32'd0);
        chk("rst_data", imWriteData, 32'd0);
        chk("rst_hold", 32'(cpuHold), 32'd1);
        chk("rst_done", 32'(loadDone), 32'd0);
        chk("rst_err", 32'(loadError), 32'd0);
        chk("rst_nwr", 32'(wr_addr.size()), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        pulse_start();
        send_first(stream.size(), 20);
        check_load("reload");

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum accepted, then corrupted
        clear_log();
        exp_words = '{32'h12345678};
        build_stream();
        chk("csum_byte", 32'(stream[$]), 32'h08);
        pulse_start();
        send_first(stream.size(), 0);
        check_load("csum_ok");
        clear_log();
        stream[stream.size() - 1] = 8'h09;
        pulse_start();
        send_first(stream.size(), 0);
        chk("csum_bad_err", 32'(loadError), 32'd1);
        repeat (2) @(negedge clk);
        chk("csum_bad_done", 32'(loadDone), 32'd0);
        chk("csum_bad_hold", 32'(cpuHold), 32'd1);
        chk("csum_bad_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_data.size() > 0) chk("csum_bad_data", wr_data[0], 32'h12345678);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1);
    end

endmodule
